// File: rtl/channel_sequencer.sv
// ---------------------------------------------------------------------------
// channel_sequencer
//
// Pops time-tagged operations from a channel FIFO and issues each one on the
// pulse interface once the global time reaches the entry's time tag. Entries
// whose tag has already passed when they are loaded are still issued, but
// they are flagged in a sticky error bit and a saturating counter. Entries
// carrying opcode 0 are popped and dropped without being issued.
//
// Parameters
//   TW  time-tag width
//   DW  payload width, laid out as {opcode[4:0], mask[1:0], angle[10:0]}
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   run          fetch enable; low blocks new FIFO pops only
//   sys_time     free-running global time (wraps modulo 2^TW)
//   fifo_empty   channel FIFO empty flag
//   fifo_rd_en   one-cycle pop request
//   fifo_rt      popped entry time tag, valid the cycle after fifo_rd_en
//   fifo_rd      popped entry payload, valid the cycle after fifo_rd_en
//   pulse_valid  issued operation valid
//   pulse_ready  downstream accepts the operation
//   pulse_opcode issued opcode (0 while pulse_valid is low)
//   pulse_mask   issued qubit mask (0 while pulse_valid is low)
//   pulse_angle  issued angle (0 while pulse_valid is low)
//   late_err     sticky flag: an entry was loaded after its time
//   late_cnt     saturating count of late entries
//   clear_err    clears late_err and late_cnt (wins over a new late event)
//   busy         high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module channel_sequencer #(
  parameter int TW = 20,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [TW-1:0] sys_time,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [TW-1:0] fifo_rt,
  input  logic [DW-1:0] fifo_rd,
  output logic          pulse_valid,
  input  logic          pulse_ready,
  output logic [4:0]    pulse_opcode,
  output logic [1:0]    pulse_mask,
  output logic [10:0]   pulse_angle,
  output logic          late_err,
  output logic [7:0]    late_cnt,
  input  logic          clear_err,
  output logic          busy
);

  // Payload field positions.
  localparam int OPC_MSB = DW - 1;
  localparam int OPC_LSB = DW - 5;
  localparam int MSK_MSB = DW - 6;
  localparam int MSK_LSB = DW - 7;
  localparam int ANG_MSB = DW - 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIRE = 3'd4
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  logic [TW-1:0] t_reg;
  logic [DW-1:0] payload_reg;
  logic          late_err_reg;
  logic [7:0]    late_cnt_reg;

  // -------------------------------------------------------------------------
  // Time comparison
  //
  // Time is compared by modular difference: the tag is reached when
  // (sys_time - tag) mod 2^TW lands in the lower half of the range. This keeps
  // the comparison correct across wrap-around of sys_time as long as tags are
  // never more than half the range away from the current time.
  // -------------------------------------------------------------------------
  logic [TW-1:0] load_diff;
  logic [TW-1:0] wait_diff;
  logic          load_reached;
  logic          load_late;
  logic          load_nop;
  logic          wait_reached;
  logic          fetch_ok;

  // During LOAD the FIFO outputs are the entry being loaded, so decisions in
  // that cycle look at fifo_rt/fifo_rd directly rather than the registers.
  assign load_diff    = sys_time - fifo_rt;
  assign wait_diff    = sys_time - t_reg;
  assign load_reached = ~load_diff[TW-1];
  assign load_late    = load_reached && (load_diff != '0);
  assign load_nop     = (fifo_rd[OPC_MSB:OPC_LSB] == 5'd0);
  assign wait_reached = ~wait_diff[TW-1];
  assign fetch_ok     = run && !fifo_empty;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fetch_ok) begin
          state_next = ST_REQ;
        end
      end
      // REQ is only entered with a non-empty FIFO and nothing but our own pop
      // can drain it, so the popped entry is always present in LOAD.
      ST_REQ: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_nop) begin
          state_next = fetch_ok ? ST_REQ : ST_IDLE;
        end else if (load_reached) begin
          state_next = ST_FIRE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      // WAIT is entered with the tag in the future; with sys_time stepping by
      // one, the first reached cycle is the one where sys_time equals t_reg.
      ST_WAIT: begin
        if (wait_reached) begin
          state_next = ST_FIRE;
        end
      end
      // run only gates the next fetch; an entry in FIRE always completes.
      ST_FIRE: begin
        if (pulse_ready) begin
          state_next = fetch_ok ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_rd_en  = 1'b0;
    pulse_valid = 1'b0;
    busy        = 1'b1;
    case (state_reg)
      ST_IDLE: busy        = 1'b0;
      ST_REQ:  fifo_rd_en  = 1'b1;
      ST_FIRE: pulse_valid = 1'b1;
      default: begin
      end
    endcase
  end

  // Payload bus is forced to zero whenever no operation is being offered, so
  // downstream never sees a stale entry on the pulse fields.
  logic [DW-1:0] pulse_bus;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_pulse_gate
      assign pulse_bus[gi] = payload_reg[gi] & pulse_valid;
    end
  endgenerate

  assign pulse_opcode = pulse_bus[OPC_MSB:OPC_LSB];
  assign pulse_mask   = pulse_bus[MSK_MSB:MSK_LSB];
  assign pulse_angle  = pulse_bus[ANG_MSB:0];

  // -------------------------------------------------------------------------
  // Entry registers: captured in LOAD and held through WAIT and FIRE, which
  // keeps the offered payload stable under backpressure.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      t_reg       <= '0;
      payload_reg <= '0;
    end else if (state_reg == ST_LOAD) begin
      t_reg       <= fifo_rt;
      payload_reg <= fifo_rd;
    end
  end

  // -------------------------------------------------------------------------
  // Late accounting. Discarded (opcode 0) entries are never counted, and a
  // clear in the same cycle as a late load takes precedence.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      late_err_reg <= 1'b0;
      late_cnt_reg <= 8'd0;
    end else if (clear_err) begin
      late_err_reg <= 1'b0;
      late_cnt_reg <= 8'd0;
    end else if ((state_reg == ST_LOAD) && !load_nop && load_late) begin
      late_err_reg <= 1'b1;
      if (late_cnt_reg != 8'hFF) begin
        late_cnt_reg <= late_cnt_reg + 8'd1;
      end
    end
  end

  assign late_err = late_err_reg;
  assign late_cnt = late_cnt_reg;

endmodule

// File: tb/tb_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_channel_sequencer
//
// Self-checking bench for channel_sequencer: a table of single-entry
// scenarios, hand-written multi-cycle sequences (backpressure, NOP discard,
// reset during WAIT, saturation and clear priority) and randomized streams
// checked against a cycle-level timing model derived from the entry times.
// ---------------------------------------------------------------------------
module tb_channel_sequencer;

  localparam int TW = 20;
  localparam int DW = 18;

  logic          clk;
  logic          reset;
  logic          run;
  logic [TW-1:0] sys_time;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [TW-1:0] fifo_rt;
  logic [DW-1:0] fifo_rd;
  logic          pulse_valid;
  logic          pulse_ready;
  logic [4:0]    pulse_opcode;
  logic [1:0]    pulse_mask;
  logic [10:0]   pulse_angle;
  logic          late_err;
  logic [7:0]    late_cnt;
  logic          clear_err;
  logic          busy;

  channel_sequencer #(.TW(TW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .sys_time     (sys_time),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rt      (fifo_rt),
    .fifo_rd      (fifo_rd),
    .pulse_valid  (pulse_valid),
    .pulse_ready  (pulse_ready),
    .pulse_opcode (pulse_opcode),
    .pulse_mask   (pulse_mask),
    .pulse_angle  (pulse_angle),
    .late_err     (late_err),
    .late_cnt     (late_cnt),
    .clear_err    (clear_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] rt;
    logic [DW-1:0] pl;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [TW-1:0] st;
    logic [DW-1:0] pl;
  } xfer_t;

  typedef struct {
    logic [TW-1:0] load_st;
    logic [TW-1:0] t;
    logic [4:0]    opc;
    logic [1:0]    msk;
    logic [10:0]   ang;
    logic [TW-1:0] exp_valid_st;
    int            exp_wait;
    logic          exp_late;
  } vec_t;

  ent_t          fifo_q[$];
  xfer_t         xfer_q[$];
  int            checks;
  int            errors;
  int            cyc;
  int            c0;
  logic          rand_mode;
  logic          rdy_pat[4096];
  logic          hold_pending;
  logic [DW-1:0] hold_pl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_pl(input logic [4:0] o, input logic [1:0] m, input logic [10:0] a);
    return {o, m, a};
  endfunction

  task automatic push(input logic [TW-1:0] rt, input logic [DW-1:0] pl);
    ent_t e;
    e.rt = rt;
    e.pl = pl;
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock. Observes the cycle that is ending, then models the
  // FIFO pop, the free-running time and (optionally) random ready.
  task automatic tick();
    logic  rd_now;
    ent_t  e;
    xfer_t x;
    if (hold_pending) begin
      chk("hold_valid", pulse_valid, 1'b1);
      chk("hold_payload", {pulse_opcode, pulse_mask, pulse_angle}, hold_pl);
    end
    hold_pending = pulse_valid && !pulse_ready && reset;
    hold_pl      = {pulse_opcode, pulse_mask, pulse_angle};
    if (!pulse_valid) chk("payload_zero_when_idle", {pulse_opcode, pulse_mask, pulse_angle}, '0);
    chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 1'b0);
    if (pulse_valid && pulse_ready && reset) begin
      x.cyc = cyc;
      x.st  = sys_time;
      x.pl  = {pulse_opcode, pulse_mask, pulse_angle};
      xfer_q.push_back(x);
      $display("xfer cyc=%0d sys_time=0x%05h opcode=%0d mask=%0d angle=0x%03h",
               cyc, sys_time, pulse_opcode, pulse_mask, pulse_angle);
    end
    rd_now = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    sys_time = sys_time + 1'b1;
    if (rd_now && fifo_q.size() > 0) begin
      e       = fifo_q.pop_front();
      fifo_rt = e.rt;
      fifo_rd = e.pl;
    end
    fifo_empty = (fifo_q.size() == 0);
    if (rand_mode) pulse_ready = rdy_pat[cyc - c0];
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    run         = 1'b0;
    clear_err   = 1'b0;
    rand_mode   = 1'b0;
    pulse_ready = 1'b1;
    fifo_q.delete();
    fifo_empty  = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    hold_pending = 1'b0;
    xfer_q.delete();
  endtask

  // Randomized stream checked against a cycle-timing model. Cycle k is counted
  // from the IDLE cycle in which run is raised (k=0); sys_time in cycle k is
  // base+k. Each entry costs REQ and LOAD cycles, then either fires on the
  // next cycle (tag reached) or on the cycle after sys_time equals the tag,
  // and transfers on the first cycle from then on where ready is high.
  task automatic run_random(input logic [TW-1:0] base, input int n);
    ent_t          ents[$];
    int            exp_k[$];
    logic [DW-1:0] exp_pl[$];
    ent_t          e;
    int            late;
    int            req_k;
    int            load_k;
    int            fire_k;
    int            f;
    logic [TW-1:0] sl;
    logic [TW-1:0] d;
    logic [TW-1:0] w;
    logic [4:0]    opc;
    do_reset();
    for (int i = 0; i < n; i++) begin
      opc  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      e.pl = mk_pl(opc, 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)));
      e.rt = base + TW'(4 * i) + TW'($urandom_range(0, 40)) - TW'(20);
      ents.push_back(e);
      push(e.rt, e.pl);
    end
    for (int k = 0; k < 4096; k++) rdy_pat[k] = ($urandom_range(0, 9) < 7);

    late  = 0;
    req_k = 1;
    foreach (ents[i]) begin
      load_k = req_k + 1;
      sl     = base + TW'(load_k);
      d      = sl - ents[i].rt;
      if (ents[i].pl[DW-1 -: 5] == 5'd0) begin
        req_k = load_k + 1;
      end else begin
        if (!d[TW-1]) begin
          fire_k = load_k + 1;
          if (d != 0) late++;
        end else begin
          w      = ents[i].rt - sl;
          fire_k = load_k + int'(w) + 1;
        end
        f = fire_k;
        while (f < 4095 && !rdy_pat[f]) f++;
        exp_k.push_back(f);
        exp_pl.push_back(ents[i].pl);
        req_k = f + 1;
      end
    end

    sys_time    = base;
    c0          = cyc;
    rand_mode   = 1'b1;
    pulse_ready = rdy_pat[0];
    run         = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (xfer_q.size() >= exp_k.size() && fifo_q.size() == 0 && !busy) break;
      tick();
    end
    rand_mode = 1'b0;
    run       = 1'b0;
    chk("rand_xfer_count", xfer_q.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < xfer_q.size(); i++) begin
      chk($sformatf("rand_xfer%0d_cycle", i), xfer_q[i].cyc - c0, exp_k[i]);
      chk($sformatf("rand_xfer%0d_payload", i), xfer_q[i].pl, exp_pl[i]);
    end
    chk("rand_late_cnt", late_cnt, (late > 255) ? 255 : late);
    chk("rand_late_err", late_err, (late > 0) ? 1 : 0);
  endtask

  initial begin
    vec_t          vecs[7];
    int            rcyc;
    logic          found;
    logic [DW-1:0] pl_a;
    logic [DW-1:0] pl_b;
    logic [DW-1:0] pl_g;
    logic [DW-1:0] pl_ref;

    vecs[0] = '{20'd90,     20'd100,    5'd19, 2'd1, 11'h155, 20'd101,    10, 1'b0};
    vecs[1] = '{20'd60,     20'd50,     5'd5,  2'd2, 11'h0AA, 20'd61,     0,  1'b1};
    vecs[2] = '{20'hFFFFA,  20'h00005,  5'd30, 2'd3, 11'h7FF, 20'd6,      11, 1'b0};
    vecs[3] = '{20'd200,    20'd200,    5'd1,  2'd0, 11'h001, 20'd201,    0,  1'b0};
    vecs[4] = '{20'h7FFFF,  20'h00000,  5'd17, 2'd1, 11'h400, 20'h80000,  0,  1'b1};
    vecs[5] = '{20'd300,    20'd301,    5'd8,  2'd2, 11'h123, 20'd302,    1,  1'b0};
    vecs[6] = '{20'd3,      20'hFFFFE,  5'd31, 2'd3, 11'h3C3, 20'd4,      0,  1'b1};

    checks       = 0;
    errors       = 0;
    cyc          = 0;
    c0           = 0;
    rand_mode    = 1'b0;
    hold_pending = 1'b0;
    hold_pl      = '0;
    reset        = 1'b0;
    run          = 1'b0;
    sys_time     = '0;
    fifo_empty   = 1'b1;
    fifo_rt      = '0;
    fifo_rd      = '0;
    pulse_ready  = 1'b1;
    clear_err    = 1'b0;

    // Raw reset edges: DUT state is unknown before the first one.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("reset_pulse_valid", pulse_valid, 1'b0);
    chk("reset_opcode", pulse_opcode, 5'd0);
    chk("reset_mask", pulse_mask, 2'd0);
    chk("reset_angle", pulse_angle, 11'd0);
    chk("reset_late_err", late_err, 1'b0);
    chk("reset_late_cnt", late_cnt, 8'd0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b1;

    // ---- Table of single-entry scenarios ---------------------------------
    for (int v = 0; v < 7; v++) begin
      do_reset();
      sys_time = vecs[v].load_st - 20'd2;
      push(vecs[v].t, mk_pl(vecs[v].opc, vecs[v].msk, vecs[v].ang));
      run   = 1'b1;
      rcyc  = -1;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        tick();
        if (fifo_rd_en && rcyc < 0) rcyc = cyc;
        if (pulse_valid) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("vec%0d_issued", v), found, 1'b1);
      if (found) begin
        chk($sformatf("vec%0d_valid_time", v), sys_time, vecs[v].exp_valid_st);
        chk($sformatf("vec%0d_wait_cycles", v), cyc - rcyc - 2, vecs[v].exp_wait);
        chk($sformatf("vec%0d_opcode", v), pulse_opcode, vecs[v].opc);
        chk($sformatf("vec%0d_mask", v), pulse_mask, vecs[v].msk);
        chk($sformatf("vec%0d_angle", v), pulse_angle, vecs[v].ang);
        chk($sformatf("vec%0d_late_err", v), late_err, vecs[v].exp_late);
        chk($sformatf("vec%0d_late_cnt", v), late_cnt, {7'd0, vecs[v].exp_late});
        tick();
        chk($sformatf("vec%0d_single_cycle", v), pulse_valid, 1'b0);
        chk($sformatf("vec%0d_idle_after", v), busy, 1'b0);
      end
      run = 1'b0;
    end

    // ---- Backpressure: payload held, no pop until transfer ----------------
    do_reset();
    sys_time    = 20'd1000;
    pl_a        = mk_pl(5'd6, 2'd3, 11'h0F0);
    pl_b        = mk_pl(5'd7, 2'd0, 11'h70F);
    push(20'd1002, pl_a);
    push(20'd1000, pl_b);
    pulse_ready = 1'b0;
    run         = 1'b1;
    found       = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (pulse_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_issued", found, 1'b1);
    pl_ref = {pulse_opcode, pulse_mask, pulse_angle};
    chk("bp_payload_a", pl_ref, pl_a);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("bp_valid_held", pulse_valid, 1'b1);
      chk("bp_payload_held", {pulse_opcode, pulse_mask, pulse_angle}, pl_ref);
      chk("bp_no_pop", fifo_rd_en, 1'b0);
    end
    pulse_ready = 1'b1;
    tick();
    chk("bp_pop_after_xfer", fifo_rd_en, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (pulse_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_second_issued", found, 1'b1);
    chk("bp_payload_b", {pulse_opcode, pulse_mask, pulse_angle}, pl_b);
    tick();
    chk("bp_xfer_count", xfer_q.size(), 2);
    if (xfer_q.size() > 0) chk("bp_first_xfer", xfer_q[0].pl, pl_a);
    run = 1'b0;

    // ---- NOP between two entries: popped, not issued, not counted ---------
    do_reset();
    sys_time = 20'd2000;
    pl_a     = mk_pl(5'd3, 2'd1, 11'h011);
    pl_b     = mk_pl(5'd9, 2'd2, 11'h099);
    push(20'd2002, pl_a);
    push(20'd100, mk_pl(5'd0, 2'd3, 11'h7FF));
    push(20'd2010, pl_b);
    run = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (xfer_q.size() >= 2 && !busy) break;
      tick();
    end
    chk("nop_xfer_count", xfer_q.size(), 2);
    if (xfer_q.size() >= 2) begin
      chk("nop_first_payload", xfer_q[0].pl, pl_a);
      chk("nop_first_time", xfer_q[0].st, 20'd2003);
      chk("nop_second_payload", xfer_q[1].pl, pl_b);
      chk("nop_second_time", xfer_q[1].st, 20'd2011);
    end
    chk("nop_all_popped", fifo_q.size(), 0);
    chk("nop_late_cnt", late_cnt, 8'd0);
    chk("nop_late_err", late_err, 1'b0);
    run = 1'b0;

    // ---- Reset during WAIT drops the held entry ---------------------------
    do_reset();
    sys_time = 20'd3000;
    pl_g     = mk_pl(5'd12, 2'd1, 11'h222);
    push(20'd3100, mk_pl(5'd21, 2'd2, 11'h111));
    push(20'd3010, pl_g);
    run = 1'b1;
    repeat (4) tick();
    chk("rst_wait_busy", busy, 1'b1);
    chk("rst_wait_not_valid", pulse_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst_pulse_valid", pulse_valid, 1'b0);
    chk("rst_payload", {pulse_opcode, pulse_mask, pulse_angle}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_late_cnt", late_cnt, 8'd0);
    reset = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (sys_time == 20'd3110) break;
      tick();
    end
    chk("rst_xfer_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) chk("rst_resumed_head", xfer_q[0].pl, pl_g);
    run = 1'b0;

    // ---- 300 late entries saturate the counter ----------------------------
    do_reset();
    sys_time = 20'd5000;
    for (int i = 0; i < 300; i++) push(20'd4000, mk_pl(5'd1, 2'd0, 11'(i)));
    run = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      if (fifo_q.size() == 0 && !busy) break;
      tick();
    end
    chk("sat_xfer_count", xfer_q.size(), 300);
    chk("sat_late_cnt", late_cnt, 8'd255);
    chk("sat_late_err", late_err, 1'b1);

    // clear_err in the same cycle as a late load: the clear wins.
    push(sys_time - 20'd50, mk_pl(5'd2, 2'd1, 11'h055));
    tick();
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_concurrent_valid", pulse_valid, 1'b1);
    chk("clr_concurrent_err", late_err, 1'b0);
    chk("clr_concurrent_cnt", late_cnt, 8'd0);
    tick();

    // Plain clear after a single late entry.
    push(sys_time - 20'd10, mk_pl(5'd4, 2'd2, 11'h0AA));
    for (int n = 0; n < 10; n++) begin
      if (fifo_q.size() == 0 && !busy) break;
      tick();
    end
    chk("clr_before_err", late_err, 1'b1);
    chk("clr_before_cnt", late_cnt, 8'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_after_err", late_err, 1'b0);
    chk("clr_after_cnt", late_cnt, 8'd0);
    run = 1'b0;

    // ---- Randomized streams ----------------------------------------------
    run_random(20'h12345, 25);
    run_random(20'hFFFC0, 25);
    run_random(20'($urandom), 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
